input_port_buffer: RTL and testbench

- Per-port wormhole input buffer for the 2D-mesh router: stores incoming flits in a FIFO, extracts the packet destination from the head flit and presents it, with a valid, to the XY route calculator.
- Holds that destination for every body/tail flit of the packet until the tail leaves, then re-arms for the next head.
- Returns one credit upstream per flit that departs.

---
 rtl/input_port_buffer_if.sv | 43 ++++
 rtl/input_port_buffer.sv | 137 +++++++++++++
 tb/tb_input_port_buffer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/input_port_buffer_if.sv
// Flit-side bundle of the wormhole input buffer: upstream write port, switch pop,
// front-flit view, route-calculator destination, credit and error flags.
`ifndef X_NODES
  `define X_NODES 4
`endif
`ifndef Y_NODES
  `define Y_NODES 4
`endif

interface input_port_buffer_if #(
  parameter int DATA_W = 32
);
  localparam int XW = $clog2(`X_NODES);
  localparam int YW = $clog2(`Y_NODES);

  logic [DATA_W-1:0] i_flit_data;
  logic              i_flit_head;
  logic              i_flit_tail;
  logic              i_flit_val;
  logic              i_pop;
  logic [DATA_W-1:0] o_flit_data;
  logic              o_flit_head;
  logic              o_flit_tail;
  logic              o_flit_val;
  logic [XW-1:0]     o_x_dest;
  logic [YW-1:0]     o_y_dest;
  logic              o_dest_val;
  logic              o_credit;
  logic              o_overflow;
  logic              o_proto_err;

  modport master (
    output i_flit_data, i_flit_head, i_flit_tail, i_flit_val, i_pop,
    input  o_flit_data, o_flit_head, o_flit_tail, o_flit_val,
    input  o_x_dest, o_y_dest, o_dest_val, o_credit, o_overflow, o_proto_err
  );

  modport slave (
    input  i_flit_data, i_flit_head, i_flit_tail, i_flit_val, i_pop,
    output o_flit_data, o_flit_head, o_flit_tail, o_flit_val,
    output o_x_dest, o_y_dest, o_dest_val, o_credit, o_overflow, o_proto_err
  );
endinterface

// File: rtl/input_port_buffer.sv
// Wormhole input buffer: flit FIFO, head-destination hold for the route calculator,
// credit return. Optional PACKET_CHECK_EN drops stray body flits and flags protocol errors.
`ifndef X_NODES
  `define X_NODES 4
`endif
`ifndef Y_NODES
  `define Y_NODES 4
`endif

module input_port_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input logic            i_clk,
  input logic            i_reset,
  input_port_buffer_if.slave bus
);
  localparam int XW = $clog2(`X_NODES);
  localparam int YW = $clog2(`Y_NODES);
  localparam int DW = XW + YW;
  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] ST_HEAD_WAIT = 1'b0;
  localparam logic [0:0] ST_BODY      = 1'b1;

  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DEPTH-1:0]  head_mem_q, tail_mem_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [0:0]        state_q, state_d;
  logic [DW-1:0]     dest_q, dest_d;
  logic              credit_q, credit_d;
  logic              overflow_q, overflow_d;
  logic              proto_err_q, proto_err_d;

  logic              empty_s, full_s, pop_s, wr_s, drop_s, body_head_s;
  logic [DATA_W-1:0] front_data_s;
  logic              front_head_s, front_tail_s;

  always_comb begin
    empty_s      = (count_q == {(AW+1){1'b0}});
    full_s       = (count_q == (AW+1)'(DEPTH));
    // Gate the front view so stale storage never leaks out while empty.
    front_data_s = empty_s ? {DATA_W{1'b0}} : data_mem_q[rd_ptr_q];
    front_head_s = empty_s ? 1'b0 : head_mem_q[rd_ptr_q];
    front_tail_s = empty_s ? 1'b0 : tail_mem_q[rd_ptr_q];
`ifdef PACKET_CHECK_EN
    drop_s       = (state_q == ST_HEAD_WAIT) && !empty_s && !front_head_s;
    body_head_s  = (state_q == ST_BODY) && !empty_s && front_head_s;
`else
    drop_s       = 1'b0;
    body_head_s  = 1'b0;
`endif
    pop_s        = (bus.i_pop && !empty_s) || drop_s;
    wr_s         = bus.i_flit_val && (!full_s || pop_s);

    wr_ptr_d     = wr_s  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    state_d = state_q;
    dest_d  = dest_q;
    if (pop_s) begin
      if (state_q == ST_HEAD_WAIT) begin
        if (!drop_s && !front_tail_s) begin
          state_d = ST_BODY;
          dest_d  = front_data_s[DW-1:0];
        end else begin
          state_d = ST_HEAD_WAIT;
        end
      end else if (front_tail_s) begin
        state_d = ST_HEAD_WAIT;
      end else begin
        state_d = ST_BODY;
      end
    end else begin
      state_d = state_q;
    end

    credit_d    = pop_s;
    overflow_d  = overflow_q | (bus.i_flit_val && full_s && !pop_s);
    proto_err_d = proto_err_q | drop_s | body_head_s;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {(AW+1){1'b0}};
      state_q     <= ST_HEAD_WAIT;
      dest_q      <= {DW{1'b0}};
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      dest_q      <= dest_d;
      credit_q    <= credit_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge i_clk) begin
    if (wr_s) begin
      data_mem_q[wr_ptr_q] <= bus.i_flit_data;
      head_mem_q[wr_ptr_q] <= bus.i_flit_head;
      tail_mem_q[wr_ptr_q] <= bus.i_flit_tail;
    end
  end

  always_comb begin
    bus.o_flit_data = front_data_s;
    bus.o_flit_head = front_head_s;
    bus.o_flit_tail = front_tail_s;
    bus.o_flit_val  = !empty_s;
    bus.o_dest_val  = !empty_s && !drop_s;
    bus.o_credit    = credit_q;
    bus.o_overflow  = overflow_q;
    bus.o_proto_err = proto_err_q;
    if (state_q == ST_BODY) begin
      bus.o_x_dest = dest_q[XW-1:0];
      bus.o_y_dest = dest_q[DW-1:XW];
    end else begin
      bus.o_x_dest = front_data_s[XW-1:0];
      bus.o_y_dest = front_data_s[DW-1:XW];
    end
  end
endmodule

// File: tb/tb_input_port_buffer.sv
// Bench for input_port_buffer: queue-level packet model checked every cycle, plus directed
// literal expectations. Builds with or without PACKET_CHECK_EN.
`ifndef X_NODES
  `define X_NODES 4
`endif
`ifndef Y_NODES
  `define Y_NODES 4
`endif

module tb_input_port_buffer;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int XW = $clog2(`X_NODES);
  localparam int YW = $clog2(`Y_NODES);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_port_buffer_if #(.DATA_W(DATA_W)) bus ();
  input_port_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              h;
    logic              t;
  } flit_t;

  // Model: the buffer as a plain queue plus "inside a packet" flag and held destination.
  flit_t           mq[$];
  bit              m_body = 1'b0;
  logic [XW+YW-1:0] m_dest = '0;
  bit              m_credit = 1'b0, m_ovf = 1'b0, m_perr = 1'b0;

  function automatic bit m_drop();
`ifdef PACKET_CHECK_EN
    return !m_body && mq.size() > 0 && !mq[0].h;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_body = 1'b0; m_dest = '0; m_credit = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
    end else begin
      bit nonempty, drop, pop, wr;
      flit_t f, nf;
      nonempty = mq.size() > 0;
      drop = m_drop();
      pop  = (bus.i_pop && nonempty) || drop;
      wr   = bus.i_flit_val && (mq.size() < DEPTH || pop);
      if (bus.i_flit_val && mq.size() == DEPTH && !pop) m_ovf = 1'b1;
`ifdef PACKET_CHECK_EN
      if (drop || (m_body && nonempty && mq[0].h)) m_perr = 1'b1;
`endif
      m_credit = pop;
      if (pop) begin
        f = mq.pop_front();
        if (!m_body) begin
          if (!drop && !f.t) begin
            m_body = 1'b1;
            m_dest = f.d[XW+YW-1:0];
          end
        end else if (f.t) begin
          m_body = 1'b0;
        end
      end
      if (wr) begin
        nf.d = bus.i_flit_data; nf.h = bus.i_flit_head; nf.t = bus.i_flit_tail;
        mq.push_back(nf);
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      flit_t fr;
      logic [XW+YW-1:0] dsrc;
      fr   = (mq.size() > 0) ? mq[0] : '0;
      dsrc = m_body ? m_dest : fr.d[XW+YW-1:0];
      check("m_flit_val",  32'(bus.o_flit_val),  32'(mq.size() > 0));
      check("m_flit_data", 32'(bus.o_flit_data), 32'(fr.d));
      check("m_flit_head", 32'(bus.o_flit_head), 32'(fr.h));
      check("m_flit_tail", 32'(bus.o_flit_tail), 32'(fr.t));
      check("m_dest_val",  32'(bus.o_dest_val),  32'(mq.size() > 0 && !m_drop()));
      check("m_x_dest",    32'(bus.o_x_dest),    32'(dsrc[XW-1:0]));
      check("m_y_dest",    32'(bus.o_y_dest),    32'(dsrc[XW+YW-1:XW]));
      check("m_credit",    32'(bus.o_credit),    32'(m_credit));
      check("m_overflow",  32'(bus.o_overflow),  32'(m_ovf));
      check("m_proto_err", 32'(bus.o_proto_err), 32'(m_perr));
    end
  end

  task automatic drive(input logic v, input logic h, input logic t,
                       input logic [31:0] d, input logic p);
    bus.i_flit_val = v; bus.i_flit_head = h; bus.i_flit_tail = t;
    bus.i_flit_data = d; bus.i_pop = p;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flit_val"},  32'(bus.o_flit_val),  32'd0);
    check({tag, "_flit_data"}, 32'(bus.o_flit_data), 32'd0);
    check({tag, "_dest_val"},  32'(bus.o_dest_val),  32'd0);
    check({tag, "_x_dest"},    32'(bus.o_x_dest),    32'd0);
    check({tag, "_y_dest"},    32'(bus.o_y_dest),    32'd0);
    check({tag, "_credit"},    32'(bus.o_credit),    32'd0);
    check({tag, "_overflow"},  32'(bus.o_overflow),  32'd0);
    check({tag, "_proto_err"}, 32'(bus.o_proto_err), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_flit_val = 1'b0; bus.i_flit_head = 1'b0; bus.i_flit_tail = 1'b0;
    bus.i_flit_data = 32'd0; bus.i_pop = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Three-flit packet to (x=2, y=3)
    drive(1'b1, 1'b1, 1'b0, 32'h0000_000E, 1'b0);
    check("first_write_val", 32'(bus.o_flit_val), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0201, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("pkt_x", 32'(bus.o_x_dest), 32'd2);
      check("pkt_y", 32'(bus.o_y_dest), 32'd3);
      check("pkt_dval", 32'(bus.o_dest_val), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      check("pkt_credit", 32'(bus.o_credit), 32'd1);
    end
    check("pkt_drained", 32'(bus.o_flit_val), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check("pkt_credit_end", 32'(bus.o_credit), 32'd0);

    // Single-flit packet then another head
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0001, 1'b0);
    check("single_x", 32'(bus.o_x_dest), 32'd1);
    check("single_y", 32'(bus.o_y_dest), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0003, 1'b1);
    check("next_head_x", 32'(bus.o_x_dest), 32'd3);
    check("next_head_dval", 32'(bus.o_dest_val), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Fill, overflow, write+pop while full, drain
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, 1'b1, 32'h10 + 32'(i), 1'b0);
    check("full_val", 32'(bus.o_flit_val), 32'd1);
    check("full_no_ovf", 32'(bus.o_overflow), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0099, 1'b0);
    check("ovf_set", 32'(bus.o_overflow), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0020, 1'b1);
    check("ovf_sticky", 32'(bus.o_overflow), 32'd1);
    check("full_wp_front", 32'(bus.o_flit_data), 32'h11);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("full_wp_count4", 32'(bus.o_flit_val), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Head popped, body not yet arrived: destination held, valid low
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0009, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("hold_dval", 32'(bus.o_dest_val), 32'd0);
    check("hold_x", 32'(bus.o_x_dest), 32'd1);
    check("hold_y", 32'(bus.o_y_dest), 32'd2);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_00F0, 1'b0);
    check("body_dval", 32'(bus.o_dest_val), 32'd1);
    check("body_x", 32'(bus.o_x_dest), 32'd1);
    check("body_y", 32'(bus.o_y_dest), 32'd2);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0005, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

`ifdef PACKET_CHECK_EN
    // Stray body flit while waiting for a head
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0007, 1'b0);
    check("stray_dval", 32'(bus.o_dest_val), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check("stray_credit", 32'(bus.o_credit), 32'd1);
    check("stray_perr", 32'(bus.o_proto_err), 32'd1);
    check("stray_gone", 32'(bus.o_flit_val), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check("stray_credit_once", 32'(bus.o_credit), 32'd0);
`else
    // Without checking, a body flit in HEAD_WAIT is routed from its own payload
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0007, 1'b0);
    check("nochk_dval", 32'(bus.o_dest_val), 32'd1);
    check("nochk_x", 32'(bus.o_x_dest), 32'd3);
    check("nochk_y", 32'(bus.o_y_dest), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("nochk_perr", 32'(bus.o_proto_err), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
`endif

    // Reset mid-packet with a pop in flight
    drive(1'b1, 1'b1, 1'b0, 32'h0000_000A, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_000B, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_000C, 1'b1);
    bus.i_flit_val = 1'b0; bus.i_pop = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0006, 1'b0);
    check("post_rst_val", 32'(bus.o_flit_val), 32'd1);
    check("post_rst_credit", 32'(bus.o_credit), 32'd0);
    check("post_rst_ovf", 32'(bus.o_overflow), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
